// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed XLEN+1 cycle latency
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     counter;
  logic [2:0]        op;
  logic              sign_a, sign_b, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] work;

  logic              a_signed, b_signed, neg_a, neg_b;
  logic              is_div;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] work_mul, work_div;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_fix, rem_fix, fin_result;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = a_signed && src_a[XLEN-1];
    neg_b    = b_signed && src_b[XLEN-1];
  end

  // Shift-add multiply: high half accumulates, low half holds the multiplier.
  always_comb begin
    mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, mag_a} : '0);
    work_mul = {mul_sum, work[XLEN-1:1]};
  end

  // Restoring divide: high half is the partial remainder, low half dividend/quotient.
  always_comb begin
    rem_sh   = work[2*XLEN-1:XLEN-1];
    div_ge   = rem_sh >= {1'b0, mag_b};
    div_rem  = XLEN'(rem_sh - {1'b0, mag_b});
    work_div = div_ge ? {div_rem, work[XLEN-2:0], 1'b1}
                      : {work[2*XLEN-2:0], 1'b0};
  end

  always_comb begin
    is_div   = op[2];
    prod     = (sign_a ^ sign_b) ? -work : work;
    quot_fix = (sign_a ^ sign_b) ? -work[XLEN-1:0] : work[XLEN-1:0];
    rem_fix  = sign_a ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
    if (!is_div) begin
      fin_result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (op[1]) begin
      // Remainder of x/0 comes out as |x| re-signed, which is the original dividend.
      fin_result = rem_fix;
    end else begin
      fin_result = b_zero ? '1 : quot_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (counter == CW'(XLEN - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      work    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op      <= funct3;
            sign_a  <= neg_a;
            sign_b  <= neg_b;
            b_zero  <= (src_b == '0);
            mag_a   <= neg_a ? -src_a : src_a;
            mag_b   <= neg_b ? -src_b : src_b;
            work    <= funct3[2] ? {{XLEN{1'b0}}, (neg_a ? -src_a : src_a)}
                                 : {{XLEN{1'b0}}, (neg_b ? -src_b : src_b)};
            counter <= '0;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          work    <= is_div ? work_div : work_mul;
          counter <= counter + 1'b1;
        end
        FIN: begin
          result <= fin_result;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f;
    src_a  = a;
    src_b  = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    src_a  = 32'hDEAD_BEEF;
    src_b  = 32'h0BAD_F00D;
  endtask

  // Counts edges after the accept edge until done; optionally pulses start at cycle inj.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int inj);
    int n;
    int nb;
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nb++;
      if (n == inj) begin
        start  = 1'b1;
        funct3 = 3'b101;
        src_a  = 32'd100;
        src_b  = 32'd7;
      end else begin
        start  = 1'b0;
      end
    end
    check_eq({tag, " latency"}, n, 32'd33);
    check_eq({tag, " busy_cycles"}, nb, 32'd33);
    check_eq({tag, " result"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    start_op(f, a, b);
    wait_done(tag, exp, -1);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", {31'b0, busy}, 32'd0);
    check_eq("reset done", {31'b0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check_eq("done one cycle", {31'b0, done}, 32'd0);
    check_eq("result held", result, 32'hFFFF_FFEB);

    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("mul big", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780);
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
    run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2);
    run_op("divu /0", 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_op("rem /0", 3'b110, 32'h1234, 32'd0, 32'h0000_1234);
    run_op("div neg/0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_op("rem neg/0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Start while busy is ignored; start in the done cycle is accepted.
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done("busy start ignored", 32'hFFFF_FFEB, 5);
    start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("start in done cycle", 32'hFFFF_FFFE, -1);
    count_dones(40, cnt);
    check_eq("no extra done", cnt, 32'd0);

    // Reset mid-operation aborts immediately.
    start_op(3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check_eq("busy before abort", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", {31'b0, busy}, 32'd0);
    check_eq("abort done", {31'b0, done}, 32'd0);
    check_eq("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, cnt);
    check_eq("no done after abort", cnt, 32'd0);
    run_op("after abort", 3'b101, 32'd100, 32'd7, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
